// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit sides.
// The RX_PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_DATA_W         = 8;
    localparam int UART_OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
`ifdef UART_RX_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP  = 3'd4,
        RX_BREAK = 3'd5
    } rx_state_t;

    function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous level; resets to 1 (idle line).
module uart_sync2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, 8 data bits, LSB first, one stop bit.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
//
// state  | meaning
// IDLE   | waiting for line low (start edge)
// START  | verifying the start bit at mid-bit
// DATA   | shifting in 8 data bits, one mid-bit sample per bit period
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, updating data and issuing the result pulse
// BREAK  | stop bit was low; wait for line high before rearming
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF
) (
    input  logic                   uart_rx_clk,
    input  logic                   uart_rx_rst_n,
    input  logic                   uart_rx_pin,
    output logic [UART_DATA_W-1:0] uart_rx_data,
    output logic                   uart_rx_valid,
    output logic                   uart_rx_frame_err,
    output logic                   uart_rx_parity_err,
    output logic                   uart_rx_busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(UART_DATA_W);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_W - 1);

    logic line;

    uart_sync2 u_sync (
        .clk_i   (uart_rx_clk),
        .rst_n_i (uart_rx_rst_n),
        .d_i     (uart_rx_pin),
        .q_o     (line)
    );

    rx_state_t              state_q;
    logic [TICK_W-1:0]      tick_q;
    logic [TICK_W-1:0]      tick_d;
    logic [BIT_W-1:0]       bit_q;
    logic [UART_DATA_W-1:0] shift_q;
    logic [UART_DATA_W-1:0] data_q;
    logic                   valid_q;
    logic                   ferr_q;
    logic                   busy_q;
    logic                   tick_last;
`ifdef UART_RX_PARITY_EN
    logic                   par_q;
    logic                   perr_q;
`endif

    // Mid-bit sampling after the start bit happens on the wrap of the tick counter.
    assign tick_last = (tick_q == TICK_LAST);
    assign tick_d    = tick_last ? '0 : tick_q + TICK_W'(1);

    always_ff @(posedge uart_rx_clk or negedge uart_rx_rst_n) begin
        if (!uart_rx_rst_n) begin
            state_q <= RX_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            unique case (state_q)
                RX_IDLE: begin
                    if (!line) begin
                        state_q <= RX_START;
                        tick_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                RX_START: begin
                    if (tick_q == TICK_MID) begin
                        tick_q <= '0;
                        if (!line) begin
                            state_q <= RX_DATA;
                            bit_q   <= '0;
                        end else begin
                            state_q <= RX_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        tick_q <= tick_d;
                    end
                end

                RX_DATA: begin
                    tick_q <= tick_d;
                    if (tick_last) begin
                        shift_q <= {line, shift_q[UART_DATA_W-1:1]};
                        bit_q   <= bit_q + BIT_W'(1);
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= RX_PARITY;
`else
                            state_q <= RX_STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    tick_q <= tick_d;
                    if (tick_last) begin
                        par_q   <= line;
                        state_q <= RX_STOP;
                    end
                end
`endif

                RX_STOP: begin
                    tick_q <= tick_d;
                    if (tick_last) begin
                        data_q <= shift_q;
                        if (!line) begin
                            ferr_q  <= 1'b1;
                            state_q <= RX_BREAK;
                        end else begin
`ifdef UART_RX_PARITY_EN
                            if (par_q != even_parity(shift_q)) begin
                                perr_q <= 1'b1;
                            end else begin
                                valid_q <= 1'b1;
                            end
`else
                            valid_q <= 1'b1;
`endif
                            state_q <= RX_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                RX_BREAK: begin
                    tick_q <= '0;
                    if (line) begin
                        state_q <= RX_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= RX_IDLE;
                    tick_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign uart_rx_data      = data_q;
    assign uart_rx_valid     = valid_q;
    assign uart_rx_frame_err = ferr_q;
    assign uart_rx_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign uart_rx_parity_err = perr_q;
`else
    assign uart_rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames scored
// against a frame-level model of expected result pulses.
module tb_uart_rx;

    localparam int OS = 16;
    localparam int EV_VALID = 32'h100;
    localparam int EV_FERR  = 32'h200;
    localparam int EV_PERR  = 32'h300;

    logic       clk;
    logic       rst_n;
    logic       pin;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;
    logic       rx_perr;
    logic       rx_busy;

    int n_checks  = 0;
    int n_errors  = 0;
    int n_overlap = 0;
    int got_q[$];
    int exp_q[$];

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .uart_rx_clk        (clk),
        .uart_rx_rst_n      (rst_n),
        .uart_rx_pin        (pin),
        .uart_rx_data       (rx_data),
        .uart_rx_valid      (rx_valid),
        .uart_rx_frame_err  (rx_ferr),
        .uart_rx_parity_err (rx_perr),
        .uart_rx_busy       (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if ((int'(rx_valid) + int'(rx_ferr) + int'(rx_perr)) > 1) n_overlap++;
            if (rx_valid) got_q.push_back(EV_VALID | int'(rx_data));
            if (rx_ferr)  got_q.push_back(EV_FERR  | int'(rx_data));
            if (rx_perr)  got_q.push_back(EV_PERR  | int'(rx_data));
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outcome of one frame, from the line-level frame contents.
    function automatic void model_frame(input logic [7:0] b, input logic par, input logic stop);
        if (!stop)
            exp_q.push_back(EV_FERR | int'(b));
`ifdef UART_RX_PARITY_EN
        else if (int'(par) != ($countones(b) % 2))
            exp_q.push_back(EV_PERR | int'(b));
`endif
        else
            exp_q.push_back(EV_VALID | int'(b));
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pin = 1'b1;
        end
    endtask

    // Drives one frame; stops early after max_cyc cycles.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int max_cyc);
        logic lv[$];
        int   cyc;
        lv.push_back(1'b0);
        for (int i = 0; i < 8; i++) lv.push_back(b[i]);
`ifdef UART_RX_PARITY_EN
        lv.push_back(par);
`endif
        lv.push_back(stop);
        cyc = 0;
        foreach (lv[k]) begin
            for (int c = 0; c < OS; c++) begin
                if (cyc >= max_cyc) return;
                @(negedge clk);
                pin = lv[k];
                cyc++;
            end
        end
    endtask

    task automatic check_events(input string tag);
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("%s_ev%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        logic       par;
        logic       stop;
        int         gap;

        pin   = 1'b1;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_data",  rx_data,  8'h00);
        check_eq("rst_valid", rx_valid, 1'b0);
        check_eq("rst_ferr",  rx_ferr,  1'b0);
        check_eq("rst_perr",  rx_perr,  1'b0);
        check_eq("rst_busy",  rx_busy,  1'b0);
        rst_n = 1'b1;
        idle(2 * OS);

        // single good frame
        send_frame(8'hA5, 1'b0, 1'b1, 1000);
        model_frame(8'hA5, 1'b0, 1'b1);
        idle(2 * OS);
        check_events("a5");
        check_eq("a5_data", rx_data, 8'hA5);
        check_eq("a5_busy", rx_busy, 1'b0);

        // back-to-back, no idle between frames
        send_frame(8'h00, 1'b0, 1'b1, 1000);
        send_frame(8'hFF, 1'b0, 1'b1, 1000);
        model_frame(8'h00, 1'b0, 1'b1);
        model_frame(8'hFF, 1'b0, 1'b1);
        idle(2 * OS);
        check_events("b2b");

        // short glitch
        repeat (5) begin
            @(negedge clk);
            pin = 1'b0;
        end
        idle(3);
        check_eq("glitch_busy_hi", rx_busy, 1'b1);
        idle(20);
        check_eq("glitch_busy_lo", rx_busy, 1'b0);
        check_events("glitch");

        // bad stop, then line held low: break until line high
        send_frame(8'h3C, 1'b0, 1'b0, 1000);
        model_frame(8'h3C, 1'b0, 1'b0);
        repeat (40) begin
            @(negedge clk);
            pin = 1'b0;
        end
        check_eq("brk_busy_hi", rx_busy, 1'b1);
        check_events("brk");
        idle(6);
        check_eq("brk_busy_lo", rx_busy, 1'b0);
        idle(2 * OS);
        check_events("brk_quiet");
        send_frame(8'h3C, 1'b0, 1'b1, 1000);
        model_frame(8'h3C, 1'b0, 1'b1);
        idle(2 * OS);
        check_events("brk_recover");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h81, 1'b1, 1'b1, 1000);
        model_frame(8'h81, 1'b1, 1'b1);
        idle(2 * OS);
        check_events("par_bad");
        check_eq("par_bad_data", rx_data, 8'h81);
        send_frame(8'h81, 1'b0, 1'b1, 1000);
        model_frame(8'h81, 1'b0, 1'b1);
        idle(2 * OS);
        check_events("par_ok");
`endif

        // reset in the middle of data bit 4
        send_frame(8'hC3, 1'b0, 1'b1, 5 * OS + OS / 2);
        @(negedge clk);
        rst_n = 1'b0;
        pin   = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("midrst_busy", rx_busy, 1'b0);
        check_eq("midrst_data", rx_data, 8'h00);
        rst_n = 1'b1;
        idle(2 * OS);
        send_frame(8'h5A, 1'b0, 1'b1, 1000);
        model_frame(8'h5A, 1'b0, 1'b1);
        idle(2 * OS);
        check_events("midrst");
        check_eq("midrst_data2", rx_data, 8'h5A);

        // random frames
        for (int n = 0; n < 40; n++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            par  = 1'($countones(b) % 2) ^ ($urandom_range(0, 3) == 0);
            send_frame(b, par, stop, 1000);
            model_frame(b, par, stop);
            gap = stop ? $urandom_range(0, 2 * OS) : $urandom_range(OS, 3 * OS);
            idle(gap);
        end
        idle(2 * OS);
        check_events("rand");

        check_eq("pulse_overlap", n_overlap, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: OVERSAMPLE, default 16, clock cycles per bit period; even integer, 4 to 256 inclusive.
REQ-002 uart_rx_clk  input  1  single clock, OVERSAMPLE x baud rate; all state updates on its rising edge.
REQ-003 uart_rx_rst_n  input  1  asynchronous, active-low reset.
REQ-004 uart_rx_pin  input  1  serial line; idle high; asynchronous to uart_rx_clk.
REQ-005 uart_rx_data  output  8  last received byte, LSB received first.
REQ-006 uart_rx_valid  output  1  one-cycle pulse; uart_rx_data holds a new error-free byte.
REQ-007 uart_rx_frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-008 uart_rx_parity_err  output  1  one-cycle pulse; parity mismatch (constant 0 without parity, see REQ-030).
REQ-009 uart_rx_busy  output  1  high from start-bit detection until the receiver returns to IDLE.

Function
REQ-010 uart_rx_pin SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-011 States SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-012 IDLE: synchronized line low SHALL move to START, clear the tick counter and assert busy.
REQ-013 START: at tick OVERSAMPLE/2-1 (mid start bit) the line is sampled; low -> DATA with tick counter cleared; high -> glitch, back to IDLE, no output pulse.
REQ-014 DATA: one sample every OVERSAMPLE ticks (mid-bit); 8 samples shifted in LSB first; after the 8th -> PARITY if enabled, else STOP.
REQ-015 PARITY: one sample at mid-bit, compared with even parity over the 8 data bits; then STOP.
REQ-016 STOP: one sample at mid-bit; uart_rx_data SHALL update on this sample whatever the outcome.
REQ-017 Stop high, parity OK: uart_rx_valid pulses in the cycle after the stop sample; next state IDLE.
REQ-018 Stop high, parity bad: uart_rx_parity_err pulses instead of uart_rx_valid; next state IDLE.
REQ-019 Stop low: uart_rx_frame_err pulses and uart_rx_valid does not, regardless of parity; next state BREAK.
REQ-020 BREAK SHALL hold until the synchronized line is high, then go to IDLE; no new start is detected while in BREAK.
REQ-021 valid, frame_err and parity_err SHALL be mutually exclusive and each exactly one cycle wide.
REQ-022 A new start bit SHALL be accepted in the cycle after the return to IDLE; back-to-back frames lose no byte.
REQ-023 The tick counter SHALL be $clog2(OVERSAMPLE) bits, wrap from OVERSAMPLE-1 to 0, and never overflow.
REQ-024 No flow control: a byte not consumed before the next valid pulse is overwritten.

Reset
REQ-025 While uart_rx_rst_n is low: state IDLE, uart_rx_data 8'h00, valid/frame_err/parity_err/busy 0, synchronizer flops 1, counters 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no pulse; after release the receiver waits for a fresh falling edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN SHALL compile in the PARITY state and even-parity checking.
REQ-028 With UART_RX_PARITY_EN defined, the frame is start, 8 data bits, parity, stop (11 bit periods).
REQ-029 Without UART_RX_PARITY_EN, the frame is start, 8 data bits, stop (10 bit periods) and the PARITY state does not exist.
REQ-030 Without UART_RX_PARITY_EN, uart_rx_parity_err SHALL still exist as a port and be tied to 0.

Structure
REQ-031 Shared package uart_pkg SHALL hold the rx state enum, UART_DATA_W = 8 and the OVERSAMPLE default, reused by the transmit side.
REQ-032 The synchronizer SHALL be a sub-module, uart_sync2 (1-bit, reset value 1).

Verification
REQ-033 OVERSAMPLE=16, no parity, byte 0xA5 sent -> one valid pulse with data 0xA5; no error pulse.
REQ-034 Bytes 0x00 then 0xFF sent back-to-back, no idle gap -> two valid pulses, data 0x00 then 0xFF.
REQ-035 Line low for 5 cycles, then high -> no pulse; busy returns low; state IDLE.
REQ-036 Byte 0x3C with stop bit low, then line held low for 40 cycles -> frame_err pulse only; no start accepted until line high.
REQ-037 Parity enabled, 0x81 with parity bit 1 -> parity_err pulse, data 0x81; same byte with parity bit 0 -> valid pulse.
REQ-038 Reset asserted during bit 4 of a frame, then a clean 0x5A frame -> only one valid pulse, data 0x5A.
